reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 83 ++++++++
 tb/tb_reg_scoreboard.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register-hazard scoreboard for an in-order pipeline.
// It keeps one 2-bit in-flight write counter for each of the 16 architectural registers.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   issue_*         ID-stage instruction offered to EXE (valid, writes-reg, dest)
//   src1/src2       source operands; two_src marks src2 as a real operand
//   flush           taken branch squashes the presented instruction
//   wb_en/wb_dest   WB-stage register write retiring this cycle
//   freeze          combinational stall of IF/ID (instruction not issued)
//   pending         bit r set while register r has a write in flight
//   err             sticky: WB seen with no matching in-flight write
module reg_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic        issue_wb_en,
  input  logic [3:0]  issue_dest,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic        two_src,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [3:0]  wb_dest,
  output logic        freeze,
  output logic [15:0] pending,
  output logic        err
);

  logic [1:0] cnt_q [16];
  logic [1:0] cnt_d [16];
  logic       err_q;
  logic       err_d;
  logic       accept;
  logic       retire;

  always_comb begin
    pending = '0;
    for (int r = 0; r < 16; r++) begin
      pending[r] = (cnt_q[r] != 2'd0);
    end
  end

  // A full destination counter stalls issue, so a counter can never pass 3.
  // WB is deliberately ignored here: a hazard clears only after the WB edge.
  assign freeze = issue_valid &&
                  (pending[src1] ||
                   (two_src && pending[src2]) ||
                   (issue_wb_en && (cnt_q[issue_dest] == 2'd3)));

  assign accept = issue_valid && issue_wb_en && !freeze && !flush;
  // A WB to an idle register is not a retire, so a counter can never go below 0.
  assign retire = wb_en && (cnt_q[wb_dest] != 2'd0);

  always_comb begin
    for (int r = 0; r < 16; r++) begin
      cnt_d[r] = cnt_q[r];
      // An issue and a retire on the same register cancel each other.
      if (accept && (issue_dest == 4'(r)) && !(retire && (wb_dest == 4'(r)))) begin
        cnt_d[r] = cnt_q[r] + 2'd1;
      end else if (retire && (wb_dest == 4'(r)) && !(accept && (issue_dest == 4'(r)))) begin
        cnt_d[r] = cnt_q[r] - 2'd1;
      end
    end
    err_d = err_q || (wb_en && (cnt_q[wb_dest] == 2'd0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 16; r++) begin
        cnt_q[r] <= 2'd0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < 16; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_wb_en;
  logic [3:0]  issue_dest;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        two_src;
  logic        flush;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic        freeze;
  logic [15:0] pending;
  logic        err;

  reg_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_dest(issue_dest),
    .src1(src1), .src2(src2), .two_src(two_src), .flush(flush),
    .wb_en(wb_en), .wb_dest(wb_dest),
    .freeze(freeze), .pending(pending), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic       we;
    logic [3:0] dst;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       ts;
    logic       fl;
    logic       wbe;
    logic [3:0] wbd;
    logic        ef;
    logic [15:0] ep;
    logic        ee;
  } vec_t;

  int total  = 0;
  int passed = 0;

  // Reference model: number of outstanding writes per register, plus sticky error.
  int m_cnt [16];
  bit m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  function automatic vec_t mk(input logic iv, input logic we, input int dst, input int s1,
                              input int s2, input logic ts, input logic fl, input logic wbe,
                              input int wbd, input logic ef, input logic [15:0] ep, input logic ee);
    vec_t v;
    v.iv = iv; v.we = we; v.dst = 4'(dst); v.s1 = 4'(s1); v.s2 = 4'(s2);
    v.ts = ts; v.fl = fl; v.wbe = wbe; v.wbd = 4'(wbd);
    v.ef = ef; v.ep = ep; v.ee = ee;
    return v;
  endfunction

  function automatic logic [15:0] m_pend();
    logic [15:0] p;
    for (int r = 0; r < 16; r++) p[r] = (m_cnt[r] > 0);
    return p;
  endfunction

  function automatic logic m_frz(input vec_t v);
    bit blocked;
    blocked = (m_cnt[v.s1] > 0) || (v.ts && m_cnt[v.s2] > 0) || (v.we && m_cnt[v.dst] >= 3);
    return v.iv && blocked;
  endfunction

  task automatic m_step(input vec_t v);
    bit acc;
    bit ret;
    acc = v.iv && v.we && !m_frz(v) && !v.fl;
    ret = v.wbe && (m_cnt[v.wbd] > 0);
    if (v.wbe && !ret) m_err = 1'b1;
    if (acc) m_cnt[v.dst] = m_cnt[v.dst] + 1;
    if (ret) m_cnt[v.wbd] = m_cnt[v.wbd] - 1;
  endtask

  task automatic m_clear();
    for (int r = 0; r < 16; r++) m_cnt[r] = 0;
    m_err = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    issue_valid = v.iv; issue_wb_en = v.we; issue_dest = v.dst;
    src1 = v.s1; src2 = v.s2; two_src = v.ts; flush = v.fl;
    wb_en = v.wbe; wb_dest = v.wbd;
  endtask

  // Called at posedge+1: drive, sample mid-cycle, clock, advance the model.
  task automatic step(input vec_t v, input bit use_table, input string tag);
    drive(v);
    #3;
    if (use_table) begin
      chk({tag, " freeze"},  32'(freeze),  32'(v.ef));
      chk({tag, " pending"}, 32'(pending), 32'(v.ep));
      chk({tag, " err"},     32'(err),     32'(v.ee));
    end else begin
      chk({tag, " freeze"},  32'(freeze),  32'(m_frz(v)));
      chk({tag, " pending"}, 32'(pending), 32'(m_pend()));
      chk({tag, " err"},     32'(err),     32'(m_err));
    end
    @(posedge clk);
    m_step(v);
    #1;
  endtask

  function automatic logic [3:0] rnd_reg();
    if ($urandom_range(0, 7) == 0) return 4'd15;
    return 4'($urandom_range(0, 3));
  endfunction

  vec_t tbl [$];
  vec_t idle;
  vec_t rv;

  initial begin
    idle = mk(0,0,0,0,0,0,0,0,0, 0,16'h0,0);
    m_clear();
    rst = 1'b1;
    drive(mk(1,1,5,1,2,1,0,1,3, 0,16'h0,0));
    #3;
    chk("reset freeze",  32'(freeze),  32'd0);
    chk("reset pending", 32'(pending), 32'd0);
    chk("reset err",     32'(err),     32'd0);
    drive(idle);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // iv we dst s1 s2 ts fl wbe wbd | freeze pending err (pre-edge values)
    tbl.push_back(mk(0,0, 0, 0,0,0,0,0, 0, 0,16'h0000,0));
    tbl.push_back(mk(1,1, 3, 0,0,0,0,0, 0, 0,16'h0000,0)); // issue R3
    tbl.push_back(mk(1,0, 0, 3,0,0,0,0, 0, 1,16'h0008,0)); // RAW on R3
    tbl.push_back(mk(0,0, 0, 0,0,0,0,1, 3, 0,16'h0008,0)); // WB R3, no bypass
    tbl.push_back(mk(1,0, 0, 3,0,0,0,0, 0, 0,16'h0000,0)); // hazard gone
    tbl.push_back(mk(1,1, 2, 0,0,0,1,0, 0, 0,16'h0000,0)); // flushed issue R2
    tbl.push_back(mk(1,0, 0, 2,0,0,0,0, 0, 0,16'h0000,0));
    tbl.push_back(mk(1,1, 4, 0,0,0,0,0, 0, 0,16'h0000,0)); // issue R4
    tbl.push_back(mk(1,0, 0, 0,4,0,0,0, 0, 0,16'h0010,0)); // src2 ignored
    tbl.push_back(mk(1,0, 0, 0,4,1,0,0, 0, 1,16'h0010,0)); // src2 real
    tbl.push_back(mk(0,1, 4, 4,4,1,0,0, 0, 0,16'h0010,0)); // no valid -> no freeze
    tbl.push_back(mk(0,0, 0, 0,0,0,0,1, 4, 0,16'h0010,0)); // WB R4
    tbl.push_back(mk(0,0, 0, 0,0,0,0,1, 7, 0,16'h0000,0)); // WB idle R7
    tbl.push_back(mk(0,0, 0, 0,0,0,0,0, 0, 0,16'h0000,1));
    tbl.push_back(mk(1,1, 5, 0,0,0,0,0, 0, 0,16'h0000,1)); // R5 -> 1
    tbl.push_back(mk(1,1, 5, 0,0,0,0,0, 0, 0,16'h0020,1)); // R5 -> 2
    tbl.push_back(mk(1,1, 5, 0,0,0,0,0, 0, 0,16'h0020,1)); // R5 -> 3
    tbl.push_back(mk(1,1, 5, 0,0,0,0,0, 0, 1,16'h0020,1)); // full
    tbl.push_back(mk(1,1, 5, 0,0,0,0,1, 5, 1,16'h0020,1)); // full+WB -> 2
    tbl.push_back(mk(1,1, 5, 0,0,0,0,1, 5, 0,16'h0020,1)); // issue+WB -> 2
    tbl.push_back(mk(1,1, 5, 0,0,0,0,0, 0, 0,16'h0020,1)); // -> 3
    tbl.push_back(mk(1,1, 5, 0,0,0,0,0, 0, 1,16'h0020,1)); // full again
    tbl.push_back(mk(0,0, 0, 0,0,0,0,1, 5, 0,16'h0020,1)); // -> 2
    tbl.push_back(mk(0,0, 0, 0,0,0,0,1, 5, 0,16'h0020,1)); // -> 1
    tbl.push_back(mk(0,0, 0, 0,0,0,0,1, 5, 0,16'h0020,1)); // -> 0
    tbl.push_back(mk(0,0, 0, 0,0,0,0,0, 0, 0,16'h0000,1));
    tbl.push_back(mk(1,1,15, 0,0,0,0,0, 0, 0,16'h0000,1)); // issue R15
    tbl.push_back(mk(1,0, 0,15,0,0,0,0, 0, 1,16'h8000,1));
    tbl.push_back(mk(1,0, 0,15,0,0,0,1,15, 1,16'h8000,1)); // WB R15 same cycle
    tbl.push_back(mk(1,0, 0,15,0,0,0,0, 0, 0,16'h0000,1));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1, $sformatf("vec%0d", i));

    for (int i = 0; i < 400; i++) begin
      rv = mk($urandom_range(0,3) != 0, $urandom_range(0,2) != 0, int'(rnd_reg()),
              int'(rnd_reg()), int'(rnd_reg()), $urandom_range(0,1) != 0,
              $urandom_range(0,9) == 0, $urandom_range(0,1) != 0, int'(rnd_reg()),
              0, 16'h0, 0);
      step(rv, 1'b0, $sformatf("rnd%0d", i));
    end

    // Clean reset, then loads to R1/R9/R15 and an asynchronous mid-cycle reset.
    drive(idle);
    rst = 1'b1;
    #1;
    m_clear();
    chk("rst pending", 32'(pending), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(mk(1,1, 1,0,0,0,0,0,0, 0,16'h0,0), 1'b0, "load1");
    step(mk(1,1, 9,0,0,0,0,0,0, 0,16'h0,0), 1'b0, "load9");
    step(mk(1,1,15,0,0,0,0,0,0, 0,16'h0,0), 1'b0, "load15");
    step(mk(0,0, 0,0,0,0,0,1,0, 0,16'h0,0), 1'b0, "wb_idle0");
    drive(mk(1,0,0,1,9,1,0,0,0, 0,16'h0,0));
    #2;
    chk("pre_rst pending", 32'(pending), 32'h8202);
    chk("pre_rst freeze",  32'(freeze),  32'd1);
    chk("pre_rst err",     32'(err),     32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst pending", 32'(pending), 32'd0);
    chk("async_rst freeze",  32'(freeze),  32'd0);
    chk("async_rst err",     32'(err),     32'd0);
    m_clear();
    drive(idle);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(mk(1,1,1,0,0,0,0,0,0, 0,16'h0,0), 1'b0, "post_rst_issue");
    step(mk(1,0,0,1,0,0,0,0,0, 0,16'h0,0), 1'b0, "post_rst_hazard");
    chk("post_rst pending", 32'(pending), 32'h0002);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
